// File: rtl/glitch_sweep_sequencer_pkg.sv
// Shared types and widths for the glitch sweep sequencer and its axis counters.
package glitch_pkg;

    localparam int OFS_W  = 32;
    localparam int DUR_W  = 32;
    localparam int STEP_W = 16;
    localparam int CNT_W  = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_ARM,
        ST_WAIT_GLITCH,
        ST_WAIT_RESP,
        ST_REPORT,
        ST_STEP
    } state_t;

    typedef logic [1:0] result_t;

    localparam result_t RES_TIMEOUT = 2'b00;
    localparam result_t RES_NORMAL  = 2'b01;
    localparam result_t RES_HIT     = 2'b10;

    // A zero step would stall the sweep forever, so it is promoted to one.
    function automatic logic [STEP_W-1:0] eff_step(input logic [STEP_W-1:0] s);
        return (s == '0) ? STEP_W'(1) : s;
    endfunction

endpackage

// File: rtl/glitch_sweep_sequencer_sweep_axis.sv
// One sweep axis: latches start/stop/step on load, walks value upward on advance,
// and flags wrap when the next point would overflow or pass the stop value.
module sweep_axis
    import glitch_pkg::*;
#(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [W-1:0]      start,
    input  logic [W-1:0]      stop,
    input  logic [STEP_W-1:0] step,
    output logic [W-1:0]      value,
    output logic              wrap
);

    logic [W-1:0]      start_reg;
    logic [W-1:0]      stop_reg;
    logic [STEP_W-1:0] step_reg;
    logic [W-1:0]      value_reg;
    logic [W:0]        sum;

    // Candidate next point, one bit wider so a carry out of the top is visible.
    // A start above stop wraps on the first advance, giving a single point.
    always_comb begin
        sum  = {1'b0, value_reg} + {{(W + 1 - STEP_W){1'b0}}, step_reg};
        wrap = sum[W] | (sum[W-1:0] > stop_reg);
    end

    // Range capture on load; step or wrap back to start on advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_reg <= '0;
            stop_reg  <= '0;
            step_reg  <= '0;
            value_reg <= '0;
        end else if (load) begin
            start_reg <= start;
            stop_reg  <= stop;
            step_reg  <= eff_step(step);
            value_reg <= start;
        end else if (advance) begin
            value_reg <= wrap ? start_reg : sum[W-1:0];
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/glitch_sweep_sequencer.sv
// Glitch campaign sequencer: for every (offset, duration) pair it resets the
// target, arms the offset counter, waits for the glitch to finish, classifies
// the target's reply and reports one result. Duration is the inner loop.
module glitch_sweep_sequencer
    import glitch_pkg::*;
#(
    parameter int RST_HOLD     = 10_000_000,
    parameter int RESP_TIMEOUT = 1_000_000,
    parameter bit STOP_ON_HIT  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [OFS_W-1:0]  ofs_start,
    input  logic [OFS_W-1:0]  ofs_stop,
    input  logic [STEP_W-1:0] ofs_step,
    input  logic [DUR_W-1:0]  dur_start,
    input  logic [DUR_W-1:0]  dur_stop,
    input  logic [STEP_W-1:0] dur_step,
    input  logic              abort,
    input  logic              glitch_done,
    input  logic              resp_valid,
    input  logic              resp_match,
    output logic              target_reset,
    output logic              start_offset_counter,
    output logic [OFS_W-1:0]  glitch_offset,
    output logic [DUR_W-1:0]  glitch_duration,
    output logic              busy,
    output logic              result_valid,
    output logic [1:0]        result_code,
    output logic              sweep_done
);

    // The shared down-counter is loaded with N-1 so a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'(RESP_TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    result_t           code_reg, code_next;
    logic              abort_pulse_reg, abort_pulse_next;

    logic              axis_load;
    logic              dur_adv;
    logic              ofs_adv;
    logic              dur_wrap;
    logic              ofs_wrap;

    // The offset only moves when the duration axis rolls over.
    assign ofs_adv = dur_adv & dur_wrap;

    sweep_axis #(.W(DUR_W)) u_dur_axis (
        .clk     (clk),
        .rst     (rst),
        .load    (axis_load),
        .advance (dur_adv),
        .start   (dur_start),
        .stop    (dur_stop),
        .step    (dur_step),
        .value   (glitch_duration),
        .wrap    (dur_wrap)
    );

    sweep_axis #(.W(OFS_W)) u_ofs_axis (
        .clk     (clk),
        .rst     (rst),
        .load    (axis_load),
        .advance (ofs_adv),
        .start   (ofs_start),
        .stop    (ofs_stop),
        .step    (ofs_step),
        .value   (glitch_offset),
        .wrap    (ofs_wrap)
    );

    // Next-state, counter, result classification and strobe outputs.
    always_comb begin
        state_next           = state_reg;
        cnt_next             = cnt_reg;
        code_next            = code_reg;
        abort_pulse_next     = 1'b0;
        axis_load            = 1'b0;
        dur_adv              = 1'b0;
        start_offset_counter = 1'b0;
        result_valid         = 1'b0;
        sweep_done           = 1'b0;

        if ((state_reg != ST_IDLE) && abort) begin
            // Abort overrides everything; the following cycle pulses target_reset
            // so the downstream offset/duration counters are cleared.
            state_next       = ST_IDLE;
            abort_pulse_next = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_valid && !abort) begin
                        axis_load  = 1'b1;
                        cnt_next   = RST_LOAD;
                        state_next = ST_RESET;
                    end
                end
                ST_RESET: begin
                    if (cnt_reg == '0) begin
                        state_next = ST_ARM;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                ST_ARM: begin
                    start_offset_counter = 1'b1;
                    state_next           = ST_WAIT_GLITCH;
                end
                ST_WAIT_GLITCH: begin
                    if (glitch_done) begin
                        cnt_next   = RESP_LOAD;
                        state_next = ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    // A reply arriving on the final timeout cycle still counts.
                    if (resp_valid) begin
                        code_next  = resp_match ? RES_HIT : RES_NORMAL;
                        state_next = ST_REPORT;
                    end else if (cnt_reg == '0) begin
                        code_next  = RES_TIMEOUT;
                        state_next = ST_REPORT;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                ST_REPORT: begin
                    result_valid = 1'b1;
                    if (STOP_ON_HIT && (code_reg == RES_HIT)) begin
                        sweep_done = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_STEP;
                    end
                end
                ST_STEP: begin
                    dur_adv = 1'b1;
                    if (dur_wrap && ofs_wrap) begin
                        sweep_done = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next   = RST_LOAD;
                        state_next = ST_RESET;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, shared counter, latched result and abort-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            code_reg        <= RES_TIMEOUT;
            abort_pulse_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            code_reg        <= code_next;
            abort_pulse_reg <= abort_pulse_next;
        end
    end

    assign target_reset = (state_reg == ST_RESET) | abort_pulse_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign result_code  = code_reg;

endmodule

// File: tb/tb_glitch_sweep_sequencer.sv
// Directed bench for glitch_sweep_sequencer with short reset hold and reply timeout.
module tb_glitch_sweep_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [31:0] ofs_start = '0, ofs_stop = '0, dur_start = '0, dur_stop = '0;
    logic [15:0] ofs_step = '0, dur_step = '0;
    logic        abort = 1'b0, glitch_done = 1'b0, resp_valid = 1'b0, resp_match = 1'b0;
    logic        target_reset, start_offset_counter, busy, result_valid, sweep_done;
    logic [31:0] glitch_offset, glitch_duration;
    logic [1:0]  result_code;

    int checks = 0;
    int failures = 0;

    glitch_sweep_sequencer #(
        .RST_HOLD     (8),
        .RESP_TIMEOUT (20),
        .STOP_ON_HIT  (1'b1)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cfg_valid            (cfg_valid),
        .ofs_start            (ofs_start),
        .ofs_stop             (ofs_stop),
        .ofs_step             (ofs_step),
        .dur_start            (dur_start),
        .dur_stop             (dur_stop),
        .dur_step             (dur_step),
        .abort                (abort),
        .glitch_done          (glitch_done),
        .resp_valid           (resp_valid),
        .resp_match           (resp_match),
        .target_reset         (target_reset),
        .start_offset_counter (start_offset_counter),
        .glitch_offset        (glitch_offset),
        .glitch_duration      (glitch_duration),
        .busy                 (busy),
        .result_valid         (result_valid),
        .result_code          (result_code),
        .sweep_done           (sweep_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [31:0] os, input logic [31:0] oe, input logic [15:0] ost,
                             input logic [31:0] ds, input logic [31:0] de, input logic [15:0] dst);
        ofs_start = os; ofs_stop = oe; ofs_step = ost;
        dur_start = ds; dur_stop = de; dur_step = dst;
        cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
    endtask

    // Runs one attempt starting in its first RESET cycle. resp_at is the
    // WAIT_RESP cycle (1-based) carrying a reply, 0 for no reply.
    task automatic run_attempt(input logic [31:0] eofs, input logic [31:0] edur, input int resp_at,
                               input bit match, input logic [1:0] ecode, input bit last);
        int n;
        int lat;
        bit got;
        n = 0;
        while (target_reset === 1'b1 && n < 100) begin
            n++;
            tick;
        end
        chk("rst_hold", n, 8);
        chk("arm_pulse", start_offset_counter, 1);
        chk("arm_ofs", glitch_offset, eofs);
        chk("arm_dur", glitch_duration, edur);
        tick;
        chk("arm_once", start_offset_counter, 0);
        repeat (3) tick;
        resp_valid = 1'b1; resp_match = 1'b1;
        tick;
        resp_valid = 1'b0; resp_match = 1'b0;
        chk("hold_busy", busy, 1);
        chk("hold_nores", result_valid, 0);
        glitch_done = 1'b1;
        tick;
        glitch_done = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            if (i == resp_at) begin
                resp_valid = 1'b1;
                resp_match = match;
            end
            tick;
            resp_valid = 1'b0;
            resp_match = 1'b0;
            if (result_valid === 1'b1) begin
                got = 1'b1;
                lat = i;
            end
        end
        chk("result_seen", got, 1);
        chk("latency", lat, (resp_at > 0) ? resp_at : 20);
        chk("code", result_code, ecode);
        chk("rep_ofs", glitch_offset, eofs);
        chk("rep_dur", glitch_duration, edur);
        $display("attempt ofs=%0h dur=%0h code=%0b latency=%0d", glitch_offset, glitch_duration, result_code, lat);
        if (ecode == 2'b10) begin
            chk("hit_done", sweep_done, 1);
            tick;
            chk("hit_idle", busy, 0);
            chk("hit_ofs", glitch_offset, eofs);
            chk("hit_dur", glitch_duration, edur);
        end else begin
            chk("rep_nodone", sweep_done, 0);
            tick;
            chk("step_done", sweep_done, last);
            tick;
            chk("after_busy", busy, last ? 0 : 1);
            if (!last) chk("next_reset", target_reset, 1);
        end
    endtask

    initial begin
        repeat (2) tick;
        chk("rst_trst", target_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ofs", glitch_offset, 0);
        chk("rst_dur", glitch_duration, 0);
        chk("rst_code", result_code, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_sd", sweep_done, 0);
        rst = 1'b0;
        tick;

        // Offset sweep 10..12, single duration.
        configure(32'd10, 32'd12, 16'd1, 32'd5, 32'd5, 16'd1);
        run_attempt(32'd10, 32'd5, 0, 1'b0, 2'b00, 1'b0);
        run_attempt(32'd11, 32'd5, 0, 1'b0, 2'b00, 1'b0);
        run_attempt(32'd12, 32'd5, 0, 1'b0, 2'b00, 1'b1);

        // Duration sweep with stop off the step grid; reply timing edges.
        configure(32'd0, 32'd0, 16'd1, 32'd100, 32'd135, 16'd10);
        run_attempt(32'd0, 32'd100, 5, 1'b0, 2'b01, 1'b0);
        run_attempt(32'd0, 32'd110, 20, 1'b0, 2'b01, 1'b0);
        run_attempt(32'd0, 32'd120, 0, 1'b0, 2'b00, 1'b0);
        run_attempt(32'd0, 32'd130, 0, 1'b0, 2'b00, 1'b1);

        // Success reply on the third attempt stops the sweep.
        configure(32'd0, 32'd9, 16'd1, 32'd1, 32'd1, 16'd1);
        run_attempt(32'd0, 32'd1, 0, 1'b0, 2'b00, 1'b0);
        run_attempt(32'd1, 32'd1, 0, 1'b0, 2'b00, 1'b0);
        run_attempt(32'd2, 32'd1, 3, 1'b1, 2'b10, 1'b0);
        repeat (3) tick;
        chk("hit_stay_idle", busy, 0);

        // Duration near the top of the range must not wrap to 0; offset step 0 acts as 1.
        configure(32'd3, 32'd4, 16'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 16'd16);
        run_attempt(32'd3, 32'hFFFF_FFF0, 0, 1'b0, 2'b00, 1'b0);
        run_attempt(32'd4, 32'hFFFF_FFF0, 2, 1'b0, 2'b01, 1'b1);

        // start > stop on both axes gives a single attempt.
        configure(32'd7, 32'd5, 16'd1, 32'd9, 32'd3, 16'd1);
        run_attempt(32'd7, 32'd9, 4, 1'b0, 2'b01, 1'b1);

        // Abort while waiting for the glitch; stray cfg_valid while busy is ignored.
        configure(32'd20, 32'd25, 16'd1, 32'd1, 32'd1, 16'd1);
        repeat (9) tick;
        chk("ab_wait_busy", busy, 1);
        ofs_start = 32'd99;
        cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        chk("busy_cfg_ignored", glitch_offset, 20);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_trst", target_reset, 1);
        chk("abort_rv", result_valid, 0);
        chk("abort_sd", sweep_done, 0);
        tick;
        chk("abort_trst_end", target_reset, 0);
        chk("abort_rv2", result_valid, 0);
        $display("abort in WAIT_GLITCH: busy=%0b target_reset=%0b", busy, target_reset);

        // abort together with cfg_valid in IDLE: abort wins, nothing starts.
        abort = 1'b1;
        cfg_valid = 1'b1;
        tick;
        abort = 1'b0;
        cfg_valid = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_trst", target_reset, 0);

        // Asynchronous reset in the middle of RESET.
        configure(32'd1, 32'd2, 16'd1, 32'd1, 32'd1, 16'd1);
        repeat (3) tick;
        chk("pre_rst_trst", target_reset, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_trst", target_reset, 0);
        chk("async_busy", busy, 0);
        chk("async_ofs", glitch_offset, 0);
        chk("async_dur", glitch_duration, 0);
        chk("async_code", result_code, 0);
        $display("async reset mid-RESET: target_reset=%0b busy=%0b", target_reset, busy);
        tick;
        rst = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
